// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state encoding, default timing constants and counter width helper for the button filter bank
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM_HI = 2'd1,
    HELD   = 2'd2,
    ARM_LO = 2'd3
  } btn_state_t;

  localparam int DEBOUNCE_CYC_10M = 10000;
  localparam int LONG_CYC_10M     = 10000000;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_filter_bank_if.sv
// rtl/btn_filter_bank_if.sv - button inputs, clears and conditioned outputs of the filter bank
interface btn_filter_bank_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] btn_i;
  logic [N_CH-1:0] clr_i;
  logic [N_CH-1:0] level_o;
  logic [N_CH-1:0] rise_o;
  logic [N_CH-1:0] fall_o;
  logic [N_CH-1:0] long_o;
  logic [N_CH-1:0] evt_o;

  modport master (
    output btn_i, clr_i,
    input  level_o, rise_o, fall_o, long_o, evt_o
  );

  modport slave (
    input  btn_i, clr_i,
    output level_o, rise_o, fall_o, long_o, evt_o
  );
endinterface

// File: rtl/btn_filter_ch.sv
// rtl/btn_filter_ch.sv - one button channel: synchroniser, debounce FSM, pulses, sticky event flag
// Long-press counter and long_o built only when BTN_LONGPRESS_EN is defined.
module btn_filter_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_10M,
  parameter int LONG_CYC     = LONG_CYC_10M,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  input  logic clr_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic long_o,
  output logic evt_o
);

  localparam int DW = cnt_width(DEBOUNCE_CYC);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync_q;
  logic          s;
  btn_state_t    state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          evt_q;

  assign s = sync_q[1] ^ ACTIVE_LOW;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 2'b00;
      state_q <= IDLE;
      dcnt_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      // A new press outranks a software clear landing in the same cycle.
      evt_q   <= rise_d | (evt_q & ~clr_i);
    end
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = ARM_HI;
          dcnt_d  = '0;
        end
      end
      ARM_HI: begin
        if (!s) begin
          state_d = IDLE;
        end else if (dcnt_q == DMAX) begin
          state_d = HELD;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!s) begin
          state_d = ARM_LO;
          dcnt_d  = '0;
        end
      end
      ARM_LO: begin
        if (s) begin
          state_d = HELD;
        end else if (dcnt_q == DMAX) begin
          state_d = IDLE;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef BTN_LONGPRESS_EN
  localparam int LW = cnt_width(LONG_CYC);
  localparam logic [LW-1:0] LMAX = LW'(LONG_CYC - 1);

  logic [LW-1:0] lcnt_q;
  logic          fired_q;
  logic          long_q;

  // lcnt saturates at LONG_CYC-1; fired_q keeps long_o to one pulse per press.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lcnt_q  <= '0;
      fired_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (fall_d) begin
        lcnt_q  <= '0;
        fired_q <= 1'b0;
      end else if (state_q == HELD) begin
        if (lcnt_q != LMAX) begin
          lcnt_q <= lcnt_q + 1'b1;
        end else if (!fired_q) begin
          long_q  <= 1'b1;
          fired_q <= 1'b1;
        end
      end
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign evt_o   = evt_q;

endmodule

// File: rtl/btn_filter_bank.sv
// rtl/btn_filter_bank.sv - N-channel push-button conditioner for the CPU peripheral bus
// Long-press detection enabled by defining BTN_LONGPRESS_EN.
module btn_filter_bank
  import btn_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_10M,
  parameter int LONG_CYC     = LONG_CYC_10M,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input logic               clk_i,
  input logic               rst_i,
  btn_filter_bank_if.slave  bus
);

  if (N_CH < 1 || N_CH > 16 || DEBOUNCE_CYC < 2) begin : g_bad_param
    $error("btn_filter_bank: N_CH must be 1..16 and DEBOUNCE_CYC at least 2");
  end

`ifdef BTN_LONGPRESS_EN
  if (LONG_CYC <= DEBOUNCE_CYC) begin : g_bad_long
    $error("btn_filter_bank: LONG_CYC must exceed DEBOUNCE_CYC");
  end
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_filter_ch #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .btn_i   (bus.btn_i[i]),
      .clr_i   (bus.clr_i[i]),
      .level_o (bus.level_o[i]),
      .rise_o  (bus.rise_o[i]),
      .fall_o  (bus.fall_o[i]),
      .long_o  (bus.long_o[i]),
      .evt_o   (bus.evt_o[i])
    );
  end

endmodule

// File: tb/tb_btn_filter_bank.sv
// tb/tb_btn_filter_bank.sv - randomized and directed bench for btn_filter_bank with a run-length reference model
// Long-press expectations follow BTN_LONGPRESS_EN.
module tb_btn_filter_bank;

  localparam int N_CH = 4;
  localparam int DEB  = 8;
  localparam int LONG = 32;
`ifdef BTN_LONGPRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  btn_filter_bank_if #(.N_CH(N_CH)) bus ();

  btn_filter_bank #(
    .N_CH         (N_CH),
    .DEBOUNCE_CYC (DEB),
    .LONG_CYC     (LONG),
    .ACTIVE_LOW   (1'b0)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: a channel flips level once the synchronised input has disagreed
  // with it for DEB+1 consecutive edges; held time counts edges spent pressed
  // with no pending disagreement.
  logic [N_CH-1:0] m_s1, m_s2, m_level, m_rise, m_fall, m_long, m_evt;
  int m_run  [N_CH];
  int m_hold [N_CH];

  function automatic logic [5*N_CH-1:0] obs_vec();
    return {bus.level_o, bus.rise_o, bus.fall_o, bus.long_o, bus.evt_o};
  endfunction

  function automatic logic [5*N_CH-1:0] exp_vec();
    return {m_level, m_rise, m_fall, m_long, m_evt};
  endfunction

  task automatic tick(input logic [N_CH-1:0] b, input logic [N_CH-1:0] c, input logic r);
    logic s;
    logic held;
    @(negedge clk);
    bus.btn_i = b;
    bus.clr_i = c;
    rst       = r;
    @(posedge clk);
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0; m_long = '0; m_evt = '0;
      for (int i = 0; i < N_CH; i++) begin
        m_run[i]  = 0;
        m_hold[i] = 0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        s    = m_s2[i];
        held = m_level[i] && (m_run[i] == 0);
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        m_long[i] = 1'b0;
        if (held) begin
          m_hold[i]++;
          if (LP_EN && m_hold[i] == LONG) m_long[i] = 1'b1;
        end
        if (s != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB + 1) begin
            m_level[i] = s;
            m_run[i]   = 0;
            if (s) m_rise[i] = 1'b1;
            else begin
              m_fall[i] = 1'b1;
              m_hold[i] = 0;
            end
          end
        end else begin
          m_run[i] = 0;
        end
        m_evt[i] = m_rise[i] | (m_evt[i] & ~c[i]);
      end
      m_s2 = m_s1;
      m_s1 = b;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int t = 0; t < 3; t++) begin
      tick('0, '0, 1'b1);
      n_checks++;
      if (obs_vec() !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %h want 0", obs_vec());
      end
    end
    for (int t = 0; t < 2; t++) tick('0, '0, 1'b0);
  endtask

  task automatic test_clean_press();
    int rise_t = -1;
    int n_rise = 0;
    logic [N_CH-1:0] other = '0;
    for (int t = 1; t <= 20; t++) begin
      tick(4'b0001, '0, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL clean_model t=%0d: got %h want %h", t, obs_vec(), exp_vec());
      end
      if (bus.rise_o[0]) begin n_rise++; rise_t = t; end
      other |= bus.level_o[3:1] | bus.rise_o[3:1] | bus.evt_o[3:1] | bus.fall_o[3:1];
    end
    n_checks += 5;
    if (rise_t !== 11) begin n_fail++; $display("FAIL clean_rise_edge: got %0d want 11", rise_t); end
    if (n_rise !== 1) begin n_fail++; $display("FAIL clean_rise_count: got %0d want 1", n_rise); end
    if (bus.level_o[0] !== 1'b1) begin n_fail++; $display("FAIL clean_level: got %b want 1", bus.level_o[0]); end
    if (bus.evt_o[0] !== 1'b1) begin n_fail++; $display("FAIL clean_evt: got %b want 1", bus.evt_o[0]); end
    if (other !== '0) begin n_fail++; $display("FAIL clean_quiet: got %b want 000", other); end
    for (int t = 0; t < 14; t++) tick('0, 4'b0001, 1'b0);
  endtask

  task automatic test_bounce();
    logic act = 1'b0;
    for (int t = 0; t < 45; t++) begin
      tick({2'b00, (t < 30) && (t % 3 == 0), 1'b0}, '0, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL bounce_model t=%0d: got %h want %h", t, obs_vec(), exp_vec());
      end
      act |= bus.level_o[1] | bus.rise_o[1] | bus.evt_o[1];
    end
    n_checks++;
    if (act !== 1'b0) begin n_fail++; $display("FAIL bounce_quiet: got %b want 0", act); end
  endtask

  task automatic test_long_press();
    for (int rep = 0; rep < 2; rep++) begin
      int rise_t = -1;
      int long_t = -1;
      int n_long = 0;
      int fall_t = -1;
      int hold_n = (rep == 0) ? 60 : 50;
      for (int t = 1; t <= hold_n; t++) begin
        tick(4'b0100, '0, 1'b0);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL long_model rep=%0d t=%0d: got %h want %h", rep, t, obs_vec(), exp_vec());
        end
        if (bus.rise_o[2]) rise_t = t;
        if (bus.long_o[2]) begin n_long++; long_t = t; end
      end
      for (int t = 1; t <= 15; t++) begin
        tick('0, 4'b0100, 1'b0);
        if (bus.fall_o[2]) fall_t = t;
      end
      n_checks += 4;
      if (rise_t !== 11) begin n_fail++; $display("FAIL long_rise_edge rep=%0d: got %0d want 11", rep, rise_t); end
      if (n_long !== (LP_EN ? 1 : 0)) begin n_fail++; $display("FAIL long_count rep=%0d: got %0d want %0d", rep, n_long, LP_EN ? 1 : 0); end
      if ((long_t < 0 ? -1 : long_t - rise_t) !== (LP_EN ? LONG : -1)) begin
        n_fail++;
        $display("FAIL long_gap rep=%0d: got %0d want %0d", rep, long_t - rise_t, LP_EN ? LONG : -1);
      end
      if (fall_t !== 11) begin n_fail++; $display("FAIL long_fall_edge rep=%0d: got %0d want 11", rep, fall_t); end
    end
  endtask

  task automatic test_evt_clear();
    for (int t = 1; t <= 12; t++) tick(4'b1000, '0, 1'b0);
    for (int t = 1; t <= 14; t++) tick('0, '0, 1'b0);
    n_checks++;
    if (bus.evt_o[3] !== 1'b1) begin n_fail++; $display("FAIL evt_sticky: got %b want 1", bus.evt_o[3]); end
    for (int t = 1; t <= 10; t++) tick(4'b1000, '0, 1'b0);
    tick(4'b1000, 4'b1000, 1'b0);
    n_checks += 2;
    if (bus.rise_o[3] !== 1'b1) begin n_fail++; $display("FAIL evt_second_rise: got %b want 1", bus.rise_o[3]); end
    if (bus.evt_o[3] !== 1'b1) begin n_fail++; $display("FAIL evt_set_wins: got %b want 1", bus.evt_o[3]); end
    tick(4'b1000, 4'b1000, 1'b0);
    n_checks++;
    if (bus.evt_o[3] !== 1'b0) begin n_fail++; $display("FAIL evt_clear: got %b want 0", bus.evt_o[3]); end
    for (int t = 1; t <= 14; t++) tick('0, '0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int rise_t = -1;
    logic any_fall = 1'b0;
    for (int t = 1; t <= 6; t++) tick(4'b0001, '0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs_vec() !== '0) begin n_fail++; $display("FAIL rstmid_async: got %h want 0", obs_vec()); end
    for (int t = 0; t < 3; t++) begin
      tick(4'b0001, '0, 1'b1);
      n_checks++;
      if (obs_vec() !== '0) begin n_fail++; $display("FAIL rstmid_hold: got %h want 0", obs_vec()); end
    end
    for (int t = 1; t <= 15; t++) begin
      tick(4'b0001, '0, 1'b0);
      if (bus.rise_o[0] && rise_t < 0) rise_t = t;
      any_fall |= |bus.fall_o;
    end
    n_checks += 2;
    if (rise_t !== 11) begin n_fail++; $display("FAIL rstmid_rise_edge: got %0d want 11", rise_t); end
    if (any_fall !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_fall: got %b want 0", any_fall); end
    for (int t = 0; t < 14; t++) tick('0, 4'b0001, 1'b0);
  endtask

  task automatic test_random();
    logic [N_CH-1:0] tgt = '0;
    logic [N_CH-1:0] b;
    logic [N_CH-1:0] c;
    logic r;
    for (int t = 0; t < 4000; t++) begin
      for (int i = 0; i < N_CH; i++) begin
        if ($urandom_range(0, 39) == 0) tgt[i] = ~tgt[i];
        b[i] = ($urandom_range(0, 9) == 0) ? ~tgt[i] : tgt[i];
        c[i] = ($urandom_range(0, 15) == 0);
      end
      r = ($urandom_range(0, 799) == 0);
      tick(b, c, r);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_model t=%0d: got %h want %h", t, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    bus.btn_i = '0;
    bus.clr_i = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_evt_clear();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_filter_bank.md
# btn_filter_bank

Parametrised N-channel push-button conditioner for the 10 MHz CPU domain. It replaces the fixed four-button filter and gives the CPU peripheral bus a single block of clean inputs. Each channel provides:
- a two-flop synchroniser;
- a counter-based debouncer with a per-channel state machine;
- single-cycle press and release pulses;
- a sticky event register that software clears;
- optional long-press detection.

## Interface
Parameters:
- N_CH, 4: number of button channels (1..16).
- DEBOUNCE_CYC, 10000: cycles an input must stay stable before it is accepted (1 ms at 10 MHz); minimum 2.
- LONG_CYC, 10000000: cycles in the pressed state before long_o fires (1 s at 10 MHz); must be greater than DEBOUNCE_CYC.
- ACTIVE_LOW, 0: 1 inverts btn_i after synchronisation (board buttons that pull to ground).

Ports:
- clk_i  in  1  system clock (10 MHz PLL output).
- rst_i  in  1  asynchronous, active-high reset.
- btn_i  in  N_CH  raw asynchronous button inputs.
- clr_i  in  N_CH  per-channel clear for evt_o; level-sensitive; sampled every cycle.
- level_o  out  N_CH  debounced button level (1 = pressed).
- rise_o  out  N_CH  one-cycle pulse when a press is accepted.
- fall_o  out  N_CH  one-cycle pulse when a release is accepted.
- long_o  out  N_CH  one-cycle pulse when a press has been held for LONG_CYC cycles.
- evt_o  out  N_CH  sticky flag, set by rise_o.

## Operation
- The synchroniser is two flops per channel. s denotes the synchronised value after ACTIVE_LOW inversion.
- Each channel has an independent state machine with states IDLE, ARM_HI, HELD, ARM_LO, and a debounce counter dcnt.
- IDLE (level 0):
  - s=1 → ARM_HI, dcnt=0.
- ARM_HI:
  - s=0 → IDLE.
  - dcnt==DEBOUNCE_CYC-1 → HELD, level_o=1, rise_o pulses.
  - otherwise dcnt++.
- HELD (level 1):
  - The long counter lcnt increments every cycle.
  - When lcnt reaches LONG_CYC-1, long_o pulses and lcnt saturates. long_o fires at most once per press.
  - s=0 → ARM_LO, dcnt=0.
- ARM_LO:
  - s=1 → back to HELD. lcnt keeps its value and does not restart.
  - dcnt==DEBOUNCE_CYC-1 → IDLE, level_o=0, fall_o pulses, lcnt=0.
  - otherwise dcnt++. lcnt is frozen in ARM_LO.
- Any glitch shorter than DEBOUNCE_CYC cycles produces no output change and no pulse.
- evt_o[i]:
  - Set on rise_o[i].
  - Cleared when clr_i[i]=1.
  - If set and clear occur in the same cycle, set wins.
- Counter widths are $clog2(DEBOUNCE_CYC) and $clog2(LONG_CYC). Neither counter wraps.

## Timing
- Reset: every flop clears asynchronously. All outputs are 0, all states are IDLE, and the synchronisers read 0.
- If btn_i is already pressed when reset is released, the channel debounces normally and rise_o fires. There are no silent presets.
- Press latency: btn_i goes to 1 (setup met before edge 1) → level_o=1 and rise_o=1 after edge DEBOUNCE_CYC+3.
- Release latency: identical, DEBOUNCE_CYC+3 edges.
- Long-press: long_o asserts LONG_CYC cycles after rise_o, provided there are no ARM_LO excursions.
- All outputs are registered. rise_o, fall_o and long_o are high for exactly one cycle.
- Channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.
- Reset asserted mid-debounce or mid-press: the state is lost immediately, and no fall_o is emitted.

## Configuration
- BTN_LONGPRESS_EN defined: lcnt and long_o logic are built as described.
- BTN_LONGPRESS_EN undefined:
  - lcnt is not instantiated.
  - long_o is tied to 0.
  - LONG_CYC is ignored and is not range-checked.
  - All other behaviour is unchanged.

## Structure
- Package btn_pkg:
  - state enum btn_state_t {IDLE, ARM_HI, HELD, ARM_LO}, 2 bits.
  - Default constants DEBOUNCE_CYC_10M=10000 and LONG_CYC_10M=10000000.
  - Width helper function.
- Sub-module btn_filter_ch: one channel, containing the synchroniser, FSM, counters and evt flag.
- btn_filter_bank instantiates N_CH copies via generate and checks parameter ranges in an elaboration-time assertion.

## Test plan
Bench parameters: N_CH=4, DEBOUNCE_CYC=8, LONG_CYC=32, BTN_LONGPRESS_EN defined unless noted.
- Clean press on ch0, held 20 cycles → level_o[0] rises at edge 11, rise_o[0] is a single pulse, evt_o[0]=1, and channels 1–3 stay quiet.
- Bounce on ch1: 1-cycle pulses every 3 cycles for 30 cycles, then low → no level_o, rise_o or evt_o activity.
- Hold ch2 for 60 cycles, then release → long_o[2] pulses exactly once, 32 cycles after rise_o[2]. fall_o[2] fires 11 edges after release, then lcnt=0.
- Set evt_o[3] via a press, then drive clr_i[3] on the same cycle as a second rise_o[3] → evt_o[3] stays 1. clr_i[3] alone one cycle later → evt_o[3]=0.
- Assert rst_i mid-ARM_HI on ch0, with btn_i held high through reset release → all outputs 0 during reset. rise_o[0] fires 11 edges after reset deasserts.
- Compile without BTN_LONGPRESS_EN, repeat the 60-cycle hold → long_o stays 0, and rise_o/fall_o timing matches the long-press run.
